// File: rtl/sideband_pkg.sv
// Shared types, limits and the arbitration helper for the sideband interrupt front-end.
package sideband_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACKD
    } sb_irq_state_e;

    localparam int unsigned NUM_IRQ_MAX = 32;

    // Lowest set index wins; returns 0 for an empty vector (callers gate on nonzero).
    function automatic logic [4:0] find_first_set(input logic [NUM_IRQ_MAX-1:0] vec);
        logic [4:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ_MAX; i++) begin
            if (vec[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sideband_sync.sv
// Single-bit, reset-to-0 multi-flop synchroniser for one asynchronous sideband line.
module sideband_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sideband_irq_ctrl.sv
// Sideband interrupt front-end: per-line sync and edge/level capture, fixed-priority
// arbitration, and a one-at-a-time req/ack handshake towards the core.
module sideband_irq_ctrl
    import sideband_pkg::*;
#(
    parameter  int NUM_IRQ     = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_edge_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    output logic               irq_req_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    output logic [NUM_IRQ-1:0] irq_pending_o
);

    logic [1:0]             rst_sync_q;
    logic [1:0]             rst_sync_d;
    logic                   rst_int_n;

    logic [NUM_IRQ-1:0]     sync_s;
    logic [NUM_IRQ-1:0]     prev_q;
    logic [NUM_IRQ-1:0]     prev_d;
    logic [NUM_IRQ-1:0]     pending_q;
    logic [NUM_IRQ-1:0]     pending_d;
    logic [NUM_IRQ_MAX-1:0] elig_ext;

    sb_irq_state_e          state_q;
    sb_irq_state_e          state_d;
    logic                   req_q;
    logic                   req_d;
    logic [ID_W-1:0]        id_q;
    logic [ID_W-1:0]        id_d;
    logic                   ack_clr;

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        sideband_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_int_n),
            .d_i  (irq_i[g]),
            .q_o  (sync_s[g])
        );
    end

    assign ack_clr = (state_q == REQ) && irq_ack_i;

    // A fresh rise outranks the ack-clear so an event arriving at ack is kept.
    always_comb begin
        prev_d    = sync_s;
        pending_d = pending_q;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge_i[i]) begin
                if (sync_s[i] && !prev_q[i]) begin
                    pending_d[i] = 1'b1;
                end else if (ack_clr && (id_q == ID_W'(i))) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = sync_s[i];
            end
        end
    end

    always_comb begin
        elig_ext              = '0;
        elig_ext[NUM_IRQ-1:0] = pending_q & irq_en_i;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (elig_ext != '0) begin
                    id_d    = ID_W'(find_first_set(elig_ext));
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    req_d   = 1'b0;
                    state_d = ACKD;
                end
            end
            ACKD: begin
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
            req_q     <= 1'b0;
            id_q      <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            req_q     <= req_d;
            id_q      <= id_d;
        end
    end

    assign irq_req_o     = req_q;
    assign irq_id_o      = id_q;
    assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_sideband_irq_ctrl.sv
// Directed bench for sideband_irq_ctrl: a cycle table for basic edge/priority flow
// plus hand sequences for level, masking, set/clear collision and mid-request reset.
module tb_sideband_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] irq;
    logic [15:0] irq_edge;
    logic [15:0] irq_en;
    logic        irq_ack;
    logic        irq_req;
    logic [3:0]  irq_id;
    logic [15:0] irq_pending;

    int n_vec;
    int n_err;

    typedef struct {
        logic [15:0] irq;
        logic        ack;
        logic        ereq;
        logic [3:0]  eid;
        logic [15:0] epend;
    } vec_t;

    vec_t vecs[$];

    sideband_irq_ctrl #(
        .NUM_IRQ    (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq),
        .irq_edge_i   (irq_edge),
        .irq_en_i     (irq_en),
        .irq_req_o    (irq_req),
        .irq_id_o     (irq_id),
        .irq_ack_i    (irq_ack),
        .irq_pending_o(irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic ereq, input logic [3:0] eid,
                           input logic [15:0] epend);
        chk({name, ".req"}, 32'(irq_req), 32'(ereq));
        chk({name, ".pend"}, 32'(irq_pending), 32'(epend));
        if (ereq) chk({name, ".id"}, 32'(irq_id), 32'(eid));
    endtask

    task automatic add(input logic [15:0] i, input logic a, input logic r,
                       input logic [3:0] id, input logic [15:0] p);
        vec_t v;
        v.irq = i; v.ack = a; v.ereq = r; v.eid = id; v.epend = p;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        irq      = '0;
        irq_edge = 16'hFFFF;
        irq_en   = 16'hFFFF;
        irq_ack  = 1'b0;

        // single edge on line 5, 3-cycle pulse
        add(16'h0020, 0, 0, 0, 16'h0000);
        add(16'h0020, 0, 0, 0, 16'h0000);
        add(16'h0020, 0, 0, 0, 16'h0020);
        add(16'h0000, 0, 1, 5, 16'h0020);
        add(16'h0000, 0, 1, 5, 16'h0020);
        add(16'h0000, 1, 0, 0, 16'h0000);
        add(16'h0000, 1, 0, 0, 16'h0000);
        add(16'h0000, 0, 0, 0, 16'h0000);
        add(16'h0000, 0, 0, 0, 16'h0000);
        // lines 9 and 3 together, line 1 arrives during REQ
        add(16'h0208, 0, 0, 0, 16'h0000);
        add(16'h0208, 0, 0, 0, 16'h0000);
        add(16'h0208, 0, 0, 0, 16'h0208);
        add(16'h020A, 0, 1, 3, 16'h0208);
        add(16'h020A, 0, 1, 3, 16'h0208);
        add(16'h020A, 0, 1, 3, 16'h020A);
        add(16'h020A, 1, 0, 0, 16'h0202);
        add(16'h020A, 1, 0, 0, 16'h0202);
        add(16'h020A, 0, 1, 1, 16'h0202);
        add(16'h020A, 1, 0, 0, 16'h0200);
        add(16'h020A, 0, 0, 0, 16'h0200);
        add(16'h020A, 0, 1, 9, 16'h0200);
        add(16'h020A, 1, 0, 0, 16'h0000);
        add(16'h0000, 0, 0, 0, 16'h0000);
        add(16'h0000, 0, 0, 0, 16'h0000);

        repeat (2) tick();
        chk("reset.req", 32'(irq_req), 32'd0);
        chk("reset.id", 32'(irq_id), 32'd0);
        chk("reset.pend", 32'(irq_pending), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < vecs.size(); i++) begin
            irq     = vecs[i].irq;
            irq_ack = vecs[i].ack;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eid, vecs[i].epend);
        end
        irq_ack = 1'b0;

        // masking: captured while disabled, requested once enabled, held when disabled again
        irq_en = 16'h0000;
        irq    = 16'h0004;
        tick(); tick();
        irq = 16'h0000;
        repeat (3) tick();
        chk_out("mask.pend", 1'b0, 4'd0, 16'h0004);
        irq_en = 16'h0004;
        tick();
        chk_out("mask.req", 1'b1, 4'd2, 16'h0004);
        irq_en = 16'h0000;
        tick();
        chk_out("mask.hold", 1'b1, 4'd2, 16'h0004);
        irq_ack = 1'b1;
        tick();
        chk_out("mask.ack", 1'b0, 4'd0, 16'h0000);
        irq_ack = 1'b0;
        irq_en  = 16'hFFFF;
        tick(); tick();

        // level mode on line 7
        irq_edge = 16'hFF7F;
        irq      = 16'h0080;
        repeat (3) tick();
        chk_out("lvl.pend", 1'b0, 4'd0, 16'h0080);
        tick();
        chk_out("lvl.req", 1'b1, 4'd7, 16'h0080);
        irq_ack = 1'b1;
        tick();
        chk_out("lvl.ack", 1'b0, 4'd0, 16'h0080);
        irq_ack = 1'b0;
        tick();
        chk_out("lvl.turn", 1'b0, 4'd0, 16'h0080);
        tick();
        chk_out("lvl.rereq", 1'b1, 4'd7, 16'h0080);
        irq = 16'h0000;
        tick(); tick();
        chk_out("lvl.drop2", 1'b1, 4'd7, 16'h0080);
        tick();
        chk_out("lvl.drop3", 1'b1, 4'd7, 16'h0000);
        irq_ack = 1'b1;
        tick();
        chk_out("lvl.ack2", 1'b0, 4'd0, 16'h0000);
        irq_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("lvl.quiet%0d", i), 1'b0, 4'd0, 16'h0000);
        end
        irq_edge = 16'hFFFF;

        // second rise on line 4 sets pending on the very edge that acks it
        irq = 16'h0010;
        tick(); tick();
        irq = 16'h0000;
        tick(); tick();
        chk_out("coll.req", 1'b1, 4'd4, 16'h0010);
        irq = 16'h0010;
        tick(); tick();
        chk_out("coll.hold", 1'b1, 4'd4, 16'h0010);
        irq_ack = 1'b1;
        tick();
        chk_out("coll.ack", 1'b0, 4'd0, 16'h0010);
        irq_ack = 1'b0;
        tick();
        chk_out("coll.turn", 1'b0, 4'd0, 16'h0010);
        tick();
        chk_out("coll.rereq", 1'b1, 4'd4, 16'h0010);
        irq_ack = 1'b1;
        tick();
        chk_out("coll.ack2", 1'b0, 4'd0, 16'h0000);
        irq_ack = 1'b0;
        irq     = 16'h0000;
        tick(); tick();

        // reset during REQ with three lines pending
        irq = 16'h1C00;
        repeat (3) tick();
        chk_out("rst.pend", 1'b0, 4'd0, 16'h1C00);
        tick();
        chk_out("rst.req", 1'b1, 4'd10, 16'h1C00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async_req", 32'(irq_req), 32'd0);
        chk("rst.async_pend", 32'(irq_pending), 32'd0);
        irq = 16'h0000;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("rst.quiet%0d", i), 1'b0, 4'd0, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sideband_irq_ctrl.md
Name: sideband_irq_ctrl

Overview:
- RTL interrupt/sideband front-end between the external sideband pins (driven in simulation by the sideband UVC) and the core's interrupt entry logic.
- Synchronises asynchronous request lines and latches per-line edge or level events.
- Arbitrates fixed-priority among them and presents one request at a time to the core over a req/ack handshake.

Parameters:
- NUM_IRQ, 16, number of sideband interrupt lines; legal range 2..32.
- SYNC_STAGES, 2, synchroniser depth per line; legal range 2..4.
- ID_W, $clog2(NUM_IRQ), derived localparam; width of irq_id_o. Not overridable.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- irq_i  in  NUM_IRQ  raw asynchronous interrupt lines, active-high.
- irq_edge_i  in  NUM_IRQ  per-line mode (quasi-static): 1 = rising-edge triggered, 0 = level.
- irq_en_i  in  NUM_IRQ  per-line enable; masks arbitration only, not capture.
- irq_req_o  out  1  request to core.
- irq_id_o  out  ID_W  index of the requested line; valid while irq_req_o = 1.
- irq_ack_i  in  1  core acceptance of the current request.
- irq_pending_o  out  NUM_IRQ  registered pending vector, for status/CSR read.

Behaviour:
- Reset (async assert, sync deassert inside the block): all sync flops, prev-value regs and pending_q are 0; FSM = IDLE; irq_req_o = 0; irq_id_o = 0; irq_pending_o = 0.
- Synchroniser: SYNC_STAGES flops per line; the synced value is s[i].
- Edge line: a rise is detected when s[i] = 1 and prev[i] = 0 (prev[i] is s[i] registered). A rise sets pending_q[i].
  - pending_q[i] is cleared only when that line is acknowledged (see IDLE/REQ/ACKD below).
  - If a set and an ack-clear of the same line happen in the same cycle, set wins, so the new event is retained.
- Level line: pending_q[i] <= s[i] every cycle. Ack does not clear it; the source must deassert.
- Eligible vector: pending_q & irq_en_i. Winner is the lowest set index (index 0 = highest priority).
- FSM states IDLE, REQ, ACKD:
  - IDLE: if the eligible vector is nonzero, register the winner into irq_id_o, assert irq_req_o and go to REQ. Otherwise stay.
  - REQ: irq_req_o = 1 and irq_id_o is held stable until ack. This holds even if the line is disabled, or a higher-priority line becomes pending (no preemption or withdrawal). On irq_ack_i = 1: deassert irq_req_o next cycle, clear pending_q[irq_id_o] if it is an edge line, go to ACKD.
  - ACKD: one turnaround cycle with irq_req_o = 0, so the cleared pending state propagates before re-arbitration. Then go to IDLE.
  - irq_ack_i is ignored in IDLE and ACKD.
- Latency: irq_i rising before clock edge k gives irq_req_o = 1 after edge k+SYNC_STAGES+1 (SYNC_STAGES+2 edges counting k). With the default, irq_req_o is seen 4 edges after first sampling.
- Back-to-back requests have a minimum spacing of 1 idle cycle after ack (ack in cycle n, next req after edge n+2).
- Pulses shorter than one clock period are not guaranteed to be captured. A pulse of at least one clk period on an edge line is captured exactly once.
- Multiple rises on one edge line while it is already pending collapse into one event. No counting.
- Mode change on a pending line while in REQ: the held request completes. The clear-on-ack decision uses irq_edge_i sampled at ack.
- Reset asserted mid-REQ: irq_req_o drops asynchronously and all pending events are lost.

Decomposition:
- sideband_pkg holds: the FSM state enum sb_irq_state_e {IDLE, REQ, ACKD}; a NUM_IRQ_MAX = 32 constant; and a find-first-set function used for arbitration.
- Sub-module sideband_sync: a parameterised SYNC_STAGES-deep, single-bit, reset-to-0 synchroniser, instantiated per line via a generate loop. The verification team constrains it separately for CDC.

Test Plan:
- Single edge: irq_edge_i = 16'hFFFF, irq_en_i = 16'hFFFF, pulse irq_i[5] for 3 clk.
  - irq_req_o rises 4 edges later with irq_id_o = 5.
  - Ack → irq_pending_o[5] = 0, req low for 1 cycle, no second request.
- Priority and hold: irq_i[9] and irq_i[3] rise together (edge mode) → id 3 first. Raise irq_i[1] during REQ → id stays 3 until ack. Next requests are id 1, then id 9, each separated by ≥1 idle cycle.
- Level mode: irq_edge_i[7] = 0, hold irq_i[7] = 1.
  - After ack, re-request of id 7 occurs 2 edges later.
  - Drop irq_i[7] → irq_pending_o[7] = 0 after SYNC_STAGES+1 edges and no further requests.
- Masking: irq_en_i = 16'h0000, pulse irq_i[2] → irq_pending_o = 16'h0004, irq_req_o stays 0. Set irq_en_i[2] = 1 → request id 2.
- Set/clear collision: second rise on irq_i[4] lands pending in the same cycle as the ack of id 4 → irq_pending_o[4] stays 1 and id 4 is requested again.
- Reset mid-operation: assert rst_n = 0 during REQ with 3 pending lines → irq_req_o = 0 immediately and irq_pending_o = 0. After release, no request without new stimulus.
